// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with stall handshake and branch redirect
//
// Owns the program counter, drives the word address of a one-cycle
// registered-read instruction memory, and presents each returned word to
// decode together with its PC. A taken branch from decode costs one bubble.
//
// Optional build macro: FETCH_PERF_EN enables the three performance counters.
// Without it the perf_* ports are tied to zero.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   mem_addr       word address to instruction memory
//   mem_instr      memory read data (word at the previous cycle's address)
//   instr          instruction presented to decode
//   instr_pc       word address of instr
//   instr_valid    instr/instr_pc meaningful
//   stall          decode cannot accept this cycle
//   branch_taken   presented instruction is a taken branch
//   branch_offset  signed word offset relative to instr_pc
//   fetch_state    debug: 0 FILL, 1 RUN, 2 REDIRECT
//   perf_fetched   accepted instructions
//   perf_bubbles   cycles with no valid instruction after reset release
//   perf_stalls    cycles presenting an instruction while stalled

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          ADDR_W   = 32,
  parameter int          OFF_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_instr,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [OFF_W-1:0]  branch_offset,
  output logic [1:0]        fetch_state,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_stalls
);

  localparam logic [1:0] ST_FILL     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pend_pc;

  logic              in_run;
  logic              accept;
  logic              branch_accept;
  logic [ADDR_W-1:0] offset_ext;

  logic [1:0]        state_nx;
  logic [ADDR_W-1:0] fetch_pc_nx;
  logic [ADDR_W-1:0] pend_pc_nx;

  assign in_run        = (state == ST_RUN);
  assign accept        = in_run & ~stall;
  assign branch_accept = accept & branch_taken;
  assign offset_ext    = {{(ADDR_W-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};

  assign instr       = mem_instr;
  assign instr_pc    = pend_pc;
  assign instr_valid = in_run;
  assign fetch_state = state;

  // Address mux. While stalled the memory re-reads pend_pc so mem_instr
  // stays stable; on a taken branch the read is discarded, so pend_pc is
  // as good as anything. mem_instr never feeds this path.
  always_comb begin
    mem_addr = fetch_pc;
    if (in_run && (stall || branch_taken)) begin
      mem_addr = pend_pc;
    end
  end

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    pend_pc_nx  = pend_pc;
    if (in_run) begin
      if (branch_accept) begin
        fetch_pc_nx = pend_pc + offset_ext;
        state_nx    = ST_REDIRECT;
      end else if (accept) begin
        pend_pc_nx  = fetch_pc;
        fetch_pc_nx = fetch_pc + 1'b1;
      end
    end else begin
      // FILL, REDIRECT and the unused encoding all issue fetch_pc and
      // move to RUN, so a corrupted state recovers in one cycle.
      pend_pc_nx  = fetch_pc;
      fetch_pc_nx = fetch_pc + 1'b1;
      state_nx    = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FILL;
      fetch_pc <= RST_PC;
      pend_pc  <= RST_PC;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      pend_pc  <= pend_pc_nx;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] cnt_fetched;
  logic [31:0] cnt_bubbles;
  logic [31:0] cnt_stalls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_fetched <= 32'd0;
      cnt_bubbles <= 32'd0;
      cnt_stalls  <= 32'd0;
    end else begin
      if (accept) begin
        cnt_fetched <= cnt_fetched + 32'd1;
      end
      if (!in_run) begin
        cnt_bubbles <= cnt_bubbles + 32'd1;
      end
      if (in_run && stall) begin
        cnt_stalls <= cnt_stalls + 32'd1;
      end
    end
  end

  assign perf_fetched = cnt_fetched;
  assign perf_bubbles = cnt_bubbles;
  assign perf_stalls  = cnt_stalls;
`else
  assign perf_fetched = 32'd0;
  assign perf_bubbles = 32'd0;
  assign perf_stalls  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl

module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        rst2;
  logic [31:0] mem_addr,  mem_addr2;
  logic [31:0] mem_instr, mem_instr2;
  logic [31:0] instr,     instr2;
  logic [31:0] instr_pc,  instr_pc2;
  logic        instr_valid, instr_valid2;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        stall2;
  logic        branch_taken2;
  logic [15:0] branch_offset2;
  logic [1:0]  fetch_state, fetch_state2;
  logic [31:0] perf_fetched, perf_bubbles, perf_stalls;
  logic [31:0] perf_fetched2, perf_bubbles2, perf_stalls2;

  logic [31:0] mem [16];

  int vecs;
  int errs;

  fetch_ctrl #(.RESET_PC(32'h00000000)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_instr(mem_instr),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .fetch_state(fetch_state), .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFFFFFF)) dut2 (
    .clk(clk), .rst(rst2), .mem_addr(mem_addr2), .mem_instr(mem_instr2),
    .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
    .stall(stall2), .branch_taken(branch_taken2), .branch_offset(branch_offset2),
    .fetch_state(fetch_state2), .perf_fetched(perf_fetched2),
    .perf_bubbles(perf_bubbles2), .perf_stalls(perf_stalls2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle registered-read instruction memory, 16 words, low bits only.
  always_ff @(posedge clk) begin
    mem_instr  <= mem[mem_addr[3:0]];
    mem_instr2 <= mem[mem_addr2[3:0]];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1;
    stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0000;
    stall2 = 1'b0; branch_taken2 = 1'b0; branch_offset2 = 16'h0000;
    #3;
    vecs++; if (instr_valid !== 1'b0) begin $display("FAIL reset_valid got %0b exp 0", instr_valid); errs++; end
    vecs++; if (instr_pc !== 32'h0) begin $display("FAIL reset_pc got %h exp 00000000", instr_pc); errs++; end
    vecs++; if (mem_addr !== 32'h0) begin $display("FAIL reset_addr got %h exp 00000000", mem_addr); errs++; end
    vecs++; if (fetch_state !== 2'd0) begin $display("FAIL reset_state got %0d exp 0", fetch_state); errs++; end
    vecs++; if (perf_fetched !== 32'd0 || perf_bubbles !== 32'd0 || perf_stalls !== 32'd0) begin
      $display("FAIL reset_perf got %0d/%0d/%0d exp 0/0/0", perf_fetched, perf_bubbles, perf_stalls); errs++; end
    vecs++; if (instr_pc2 !== 32'hFFFFFFFF) begin $display("FAIL reset_pc2 got %h exp ffffffff", instr_pc2); errs++; end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_fill_run;
    #1;
    vecs++; if (instr_valid !== 1'b0) begin $display("FAIL fill_valid got %0b exp 0", instr_valid); errs++; end
    vecs++; if (mem_addr !== 32'd0) begin $display("FAIL fill_addr got %h exp 0", mem_addr); errs++; end
    step();
    vecs++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr !== 32'h22000005) begin
      $display("FAIL run0 got v=%0b pc=%h i=%h exp v=1 pc=0 i=22000005", instr_valid, instr_pc, instr); errs++; end
    vecs++; if (mem_addr !== 32'd1) begin $display("FAIL run0_addr got %h exp 1", mem_addr); errs++; end
    step();
    vecs++; if (instr_valid !== 1'b1 || instr_pc !== 32'd1 || instr !== 32'h24400003) begin
      $display("FAIL run1 got v=%0b pc=%h i=%h exp v=1 pc=1 i=24400003", instr_valid, instr_pc, instr); errs++; end
    step();
    vecs++; if (instr_valid !== 1'b1 || instr_pc !== 32'd2 || instr !== 32'hA8000000) begin
      $display("FAIL run2 got v=%0b pc=%h i=%h exp v=1 pc=2 i=a8000000", instr_valid, instr_pc, instr); errs++; end
    step();
    vecs++; if (instr_pc !== 32'd3 || instr !== 32'hA000FFFD) begin
      $display("FAIL run3 got pc=%h i=%h exp pc=3 i=a000fffd", instr_pc, instr); errs++; end
`ifdef FETCH_PERF_EN
    vecs++; if (perf_fetched !== 32'd3 || perf_bubbles !== 32'd1 || perf_stalls !== 32'd0) begin
      $display("FAIL perf_first got %0d/%0d/%0d exp 3/1/0", perf_fetched, perf_bubbles, perf_stalls); errs++; end
`else
    vecs++; if (perf_fetched !== 32'd0 || perf_bubbles !== 32'd0 || perf_stalls !== 32'd0) begin
      $display("FAIL perf_tied got %0d/%0d/%0d exp 0/0/0", perf_fetched, perf_bubbles, perf_stalls); errs++; end
`endif
  endtask

  task automatic test_branch;
    branch_taken = 1'b1; branch_offset = 16'hFFFD;
    #1;
    vecs++; if (mem_addr !== 32'd3) begin $display("FAIL br_addr got %h exp 3", mem_addr); errs++; end
    step();
    branch_taken = 1'b0; branch_offset = 16'h0000;
    #1;
    vecs++; if (instr_valid !== 1'b0 || mem_addr !== 32'd0 || fetch_state !== 2'd2) begin
      $display("FAIL br_bubble got v=%0b a=%h s=%0d exp v=0 a=0 s=2", instr_valid, mem_addr, fetch_state); errs++; end
    step();
    vecs++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr !== 32'h22000005) begin
      $display("FAIL br_target got v=%0b pc=%h i=%h exp v=1 pc=0 i=22000005", instr_valid, instr_pc, instr); errs++; end
  endtask

  task automatic test_stall;
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++; if (instr_valid !== 1'b1 || instr_pc !== 32'd1 || instr !== 32'h24400003 || mem_addr !== 32'd1) begin
        $display("FAIL stall_hold%0d got v=%0b pc=%h i=%h a=%h exp v=1 pc=1 i=24400003 a=1",
                 k, instr_valid, instr_pc, instr, mem_addr); errs++; end
      step();
    end
    stall = 1'b0;
    #1;
    vecs++; if (instr_pc !== 32'd1 || mem_addr !== 32'd2) begin
      $display("FAIL stall_release got pc=%h a=%h exp pc=1 a=2", instr_pc, mem_addr); errs++; end
    step();
    vecs++; if (instr_pc !== 32'd2 || instr !== 32'hA8000000) begin
      $display("FAIL stall_next got pc=%h i=%h exp pc=2 i=a8000000", instr_pc, instr); errs++; end
`ifdef FETCH_PERF_EN
    vecs++; if (perf_stalls !== 32'd3) begin $display("FAIL perf_stalls got %0d exp 3", perf_stalls); errs++; end
`endif
  endtask

  task automatic test_stall_branch;
    step();
    stall = 1'b1; branch_taken = 1'b1; branch_offset = 16'hFFFD;
    #1;
    vecs++; if (instr_pc !== 32'd3 || mem_addr !== 32'd3) begin
      $display("FAIL sb_hold got pc=%h a=%h exp pc=3 a=3", instr_pc, mem_addr); errs++; end
    step();
    vecs++; if (instr_valid !== 1'b1 || instr_pc !== 32'd3 || fetch_state !== 2'd1) begin
      $display("FAIL sb_stillrun got v=%0b pc=%h s=%0d exp v=1 pc=3 s=1", instr_valid, instr_pc, fetch_state); errs++; end
    stall = 1'b0;
    step();
    branch_taken = 1'b0; branch_offset = 16'h0000;
    #1;
    vecs++; if (instr_valid !== 1'b0 || fetch_state !== 2'd2) begin
      $display("FAIL sb_bubble got v=%0b s=%0d exp v=0 s=2", instr_valid, fetch_state); errs++; end
    step();
    vecs++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0) begin
      $display("FAIL sb_target got v=%0b pc=%h exp v=1 pc=0", instr_valid, instr_pc); errs++; end
  endtask

  task automatic test_reset_mid_redirect;
    branch_taken = 1'b1; branch_offset = 16'h0002;
    step();
    branch_taken = 1'b0; branch_offset = 16'h0000;
    #1;
    vecs++; if (fetch_state !== 2'd2) begin $display("FAIL mr_redirect got %0d exp 2", fetch_state); errs++; end
    #1;
    rst = 1'b1;
    #1;
    vecs++; if (instr_valid !== 1'b0 || instr_pc !== 32'd0 || mem_addr !== 32'd0 || fetch_state !== 2'd0) begin
      $display("FAIL mr_async got v=%0b pc=%h a=%h s=%0d exp v=0 pc=0 a=0 s=0",
               instr_valid, instr_pc, mem_addr, fetch_state); errs++; end
    vecs++; if (perf_fetched !== 32'd0 || perf_bubbles !== 32'd0 || perf_stalls !== 32'd0) begin
      $display("FAIL mr_perf got %0d/%0d/%0d exp 0/0/0", perf_fetched, perf_bubbles, perf_stalls); errs++; end
    step();
    rst = 1'b0;
    step();
    vecs++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr !== 32'h22000005) begin
      $display("FAIL mr_refill got v=%0b pc=%h i=%h exp v=1 pc=0 i=22000005", instr_valid, instr_pc, instr); errs++; end
  endtask

  task automatic test_wrap;
    rst2 = 1'b0;
    #1;
    vecs++; if (instr_valid2 !== 1'b0 || mem_addr2 !== 32'hFFFFFFFF) begin
      $display("FAIL wrap_fill got v=%0b a=%h exp v=0 a=ffffffff", instr_valid2, mem_addr2); errs++; end
    step();
    vecs++; if (instr_pc2 !== 32'hFFFFFFFF || instr2 !== mem[15]) begin
      $display("FAIL wrap_pc0 got pc=%h i=%h exp pc=ffffffff i=%h", instr_pc2, instr2, mem[15]); errs++; end
    step();
    vecs++; if (instr_pc2 !== 32'h00000000 || instr2 !== 32'h22000005) begin
      $display("FAIL wrap_pc1 got pc=%h i=%h exp pc=0 i=22000005", instr_pc2, instr2); errs++; end
    step();
    vecs++; if (instr_pc2 !== 32'h00000001) begin $display("FAIL wrap_pc2 got %h exp 1", instr_pc2); errs++; end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h11111111 * i;
    mem[0] = 32'h22000005;
    mem[1] = 32'h24400003;
    mem[2] = 32'hA8000000;
    mem[3] = 32'hA000FFFD;
    mem[15] = 32'hDEADBEEF;

    test_reset();
    test_fill_run();
    test_branch();
    test_stall();
    test_stall_branch();
    test_reset_mid_redirect();
    test_wrap();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
